// File: rtl/mc_ctrl_pkg.sv
// Purpose: shared types and encodings for the multicycle controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_BRANCH = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
        CLS_J, CLS_JAL, CLS_JR, CLS_ILL
    } cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_RTYPE = 5'b00010;
    localparam logic [4:0] ALU_SLT   = 5'b00011;
    localparam logic [4:0] ALU_AND   = 5'b00100;
    localparam logic [4:0] ALU_OR    = 5'b00101;
    localparam logic [4:0] ALU_XOR   = 5'b00110;
    localparam logic [4:0] ALU_LUI   = 5'b00111;
    localparam logic [4:0] ALU_SLTU  = 5'b01000;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

    // Loads and stores are the only classes that visit the MEM state.
    function automatic logic is_mem_cls(cls_t c);
        return (c == CLS_LW) || (c == CLS_SW);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Purpose: controller <-> datapath/memory signal bundle.
// Latency: n/a (wires only).
// Backpressure: memory stalls the controller through mem_ready.
interface mc_ctrl_if #(parameter int ALU_OP_W = 5);
    logic [5:0]          opcode;
    logic [5:0]          funct;
    logic                zero;
    logic                mem_ready;
    logic                mem_req;
    logic                mem_we;
    logic                i_or_d;
    logic                ir_write;
    logic                pc_write;
    logic                reg_write;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                alu_src_a;
    logic                is_signed;
    logic                link;
    logic [1:0]          alu_src_b;
    logic [1:0]          pc_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [2:0]          state_o;
    logic                timeout;
    logic                illegal_op;
    logic                halted;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, is_signed, link, alu_src_b, pc_src,
               alu_op, state_o, timeout, illegal_op, halted
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, reg_write, reg_dst,
               mem_to_reg, alu_src_a, is_signed, link, alu_src_b, pc_src,
               alu_op, state_o, timeout, illegal_op, halted
    );
endinterface

// File: rtl/mc_ctrl_dec.sv
// Purpose: classify opcode/funct into instruction class, EXEC alu_op and immediate signedness.
// Latency: combinational, zero cycles.
// Backpressure: none.
module mc_ctrl_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic [4:0] alu_op,
    output logic       is_signed
);

    // Anything not matched below stays CLS_ILL; logical immediates zero-extend.
    always_comb begin
        cls       = CLS_ILL;
        alu_op    = ALU_ADD;
        is_signed = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FN_JR) begin
                    cls = CLS_JR;
                end else begin
                    cls    = CLS_ALU_R;
                    alu_op = ALU_RTYPE;
                end
            end
            OP_ADDI:  cls = CLS_ALU_I;
            OP_SLTI:  begin cls = CLS_ALU_I; alu_op = ALU_SLT;  end
            OP_SLTIU: begin cls = CLS_ALU_I; alu_op = ALU_SLTU; end
            OP_ANDI:  begin cls = CLS_ALU_I; alu_op = ALU_AND; is_signed = 1'b0; end
            OP_ORI:   begin cls = CLS_ALU_I; alu_op = ALU_OR;  is_signed = 1'b0; end
            OP_XORI:  begin cls = CLS_ALU_I; alu_op = ALU_XOR; is_signed = 1'b0; end
            OP_LUI:   begin cls = CLS_ALU_I; alu_op = ALU_LUI;  end
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BEQ:   begin cls = CLS_BEQ; alu_op = ALU_SUB; end
            OP_BNE:   begin cls = CLS_BNE; alu_op = ALU_SUB; end
            OP_J:     cls = CLS_J;
            OP_JAL:   cls = CLS_JAL;
            default:  cls = CLS_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Purpose: multicycle CPU control FSM with memory wait-timeout trap; MC_CTRL_ILLEGAL_TRAP_EN traps unknown opcodes.
// Latency: J/JAL/JR 2, BEQ/BNE 3, ALU/SW 4, LW 5 cycles with zero-wait memory.
// Backpressure: FETCH and MEM hold until mem_ready; MAX_WAIT stalled cycles then TRAP.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic     clk,
    input  logic     rst,
    mc_ctrl_if.master bus
);

    localparam int              CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             run;
    logic             timeout_q;
    logic             halted_q;
    logic             wait_expired;

    cls_t             cls;
    logic [4:0]       dec_alu_op;
    logic             dec_signed;

    logic             mem_req_c, mem_we_c, i_or_d_c, ir_write_c, pc_write_c;
    logic             reg_write_c, reg_dst_c, mem_to_reg_c, alu_src_a_c, link_c;
    logic [1:0]       alu_src_b_c, pc_src_c;
    logic [4:0]       alu_op_c;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    logic             illegal_q;
    logic             go_illegal;
`endif

    mc_ctrl_dec u_dec (
        .opcode    (bus.opcode),
        .funct     (bus.funct),
        .cls       (cls),
        .alu_op    (dec_alu_op),
        .is_signed (dec_signed)
    );

    // Control word per state; run gates the first fetch until one edge after reset release.
    always_comb begin
        mem_req_c    = 1'b0;
        mem_we_c     = 1'b0;
        i_or_d_c     = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        alu_src_a_c  = 1'b0;
        link_c       = 1'b0;
        alu_src_b_c  = SRCB_B;
        pc_src_c     = PC_ALU;
        alu_op_c     = ALU_ADD;
        case (state)
            ST_FETCH: begin
                mem_req_c   = run;
                alu_src_b_c = SRCB_FOUR;
                if (run && bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                end
            end
            ST_DECODE: begin
                alu_src_b_c = SRCB_IMM_SH;
                case (cls)
                    CLS_J:   begin pc_write_c = 1'b1; pc_src_c = PC_JUMP; end
                    CLS_JAL: begin
                        pc_write_c  = 1'b1;
                        pc_src_c    = PC_JUMP;
                        reg_write_c = 1'b1;
                        link_c      = 1'b1;
                    end
                    CLS_JR:  begin pc_write_c = 1'b1; pc_src_c = PC_RS; end
                    default: pc_write_c = 1'b0;
                endcase
            end
            ST_EXEC: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = dec_alu_op;
                alu_src_b_c = (cls == CLS_ALU_R) ? SRCB_B : SRCB_IMM;
            end
            ST_BRANCH: begin
                alu_src_a_c = 1'b1;
                alu_op_c    = ALU_SUB;
                pc_src_c    = PC_ALUOUT;
                pc_write_c  = ((cls == CLS_BEQ) && bus.zero) || ((cls == CLS_BNE) && !bus.zero);
            end
            ST_MEM: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
                mem_we_c  = (cls == CLS_SW);
            end
            ST_WB: begin
                reg_write_c  = 1'b1;
                reg_dst_c    = (cls == CLS_ALU_R);
                mem_to_reg_c = (cls == CLS_LW);
            end
            default: alu_op_c = ALU_ADD;
        endcase
    end

    // Next state; an expired wait overrides everything, but a same-cycle mem_ready wins.
    always_comb begin
        state_nxt    = state;
        wait_expired = mem_req_c && !bus.mem_ready && (wait_cnt == WAIT_LIM);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        go_illegal   = 1'b0;
`endif
        case (state)
            ST_FETCH:  if (mem_req_c && bus.mem_ready) state_nxt = ST_DECODE;
            ST_DECODE: begin
                case (cls)
                    CLS_ALU_R, CLS_ALU_I, CLS_LW, CLS_SW: state_nxt = ST_EXEC;
                    CLS_BEQ, CLS_BNE:                     state_nxt = ST_BRANCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    CLS_ILL: begin
                        state_nxt  = ST_TRAP;
                        go_illegal = 1'b1;
                    end
`endif
                    default:                              state_nxt = ST_FETCH;
                endcase
            end
            ST_EXEC:   state_nxt = is_mem_cls(cls) ? ST_MEM : ST_WB;
            ST_BRANCH: state_nxt = ST_FETCH;
            ST_MEM:    if (bus.mem_ready) state_nxt = (cls == CLS_LW) ? ST_WB : ST_FETCH;
            ST_WB:     state_nxt = ST_FETCH;
            default:   state_nxt = ST_TRAP;
        endcase
        if (wait_expired) state_nxt = ST_TRAP;
    end

    // State, wait counter and sticky status; TRAP is left only through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FETCH;
            wait_cnt  <= '0;
            run       <= 1'b0;
            timeout_q <= 1'b0;
            halted_q  <= 1'b0;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            run   <= 1'b1;
            state <= state_nxt;
            if (bus.mem_ready || (state_nxt != state)) begin
                wait_cnt <= '0;
            end else if (mem_req_c) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (wait_expired)          timeout_q <= 1'b1;
            if (state_nxt == ST_TRAP)  halted_q  <= 1'b1;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (go_illegal)            illegal_q <= 1'b1;
`endif
        end
    end

    assign bus.mem_req    = mem_req_c;
    assign bus.mem_we     = mem_we_c;
    assign bus.i_or_d     = i_or_d_c;
    assign bus.ir_write   = ir_write_c;
    assign bus.pc_write   = pc_write_c;
    assign bus.reg_write  = reg_write_c;
    assign bus.reg_dst    = reg_dst_c;
    assign bus.mem_to_reg = mem_to_reg_c;
    assign bus.alu_src_a  = alu_src_a_c;
    assign bus.is_signed  = dec_signed;
    assign bus.link       = link_c;
    assign bus.alu_src_b  = alu_src_b_c;
    assign bus.pc_src     = pc_src_c;
    assign bus.alu_op     = ALU_OP_W'(alu_op_c);
    assign bus.state_o    = state;
    assign bus.timeout    = timeout_q;
    assign bus.halted     = halted_q;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal_op = illegal_q;
`else
    assign bus.illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Purpose: self-checking bench for mc_ctrl: per-cycle vector table plus wait/timeout/reset sequences.
// Latency: n/a.
// Backpressure: mem_ready driven directly by the vectors.
module tb_mc_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.ALU_OP_W(5)) bus ();

    mc_ctrl #(.ALU_OP_W(5), .MAX_WAIT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_JR  = 6'b001000;
    localparam logic [5:0] O_R   = 6'b000000;
    localparam logic [5:0] O_AND = 6'b001100;
    localparam logic [5:0] O_XOR = 6'b001110;
    localparam logic [5:0] O_BEQ = 6'b000100;
    localparam logic [5:0] O_BNE = 6'b000101;
    localparam logic [5:0] O_J   = 6'b000010;
    localparam logic [5:0] O_JAL = 6'b000011;
    localparam logic [5:0] O_LW  = 6'b100011;
    localparam logic [5:0] O_SW  = 6'b101011;
    localparam logic [5:0] O_BAD = 6'b111111;

    // ctl = {mem_req,mem_we,i_or_d, ir_write,pc_write,reg_write, reg_dst,mem_to_reg,alu_src_a, link,is_signed, alu_src_b, pc_src}
    // sts = {timeout, illegal_op, halted}
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rdy;
        logic [2:0]  st;
        logic [14:0] ctl;
        logic [4:0]  aop;
        logic [2:0]  sts;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, logic z, logic rdy,
                                logic [2:0] st, logic [14:0] ctl, logic [4:0] aop, logic [2:0] sts);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy;
        v.st = st; v.ctl = ctl; v.aop = aop; v.sts = sts;
        return v;
    endfunction

    function automatic logic [14:0] ctl_now();
        return {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write, bus.reg_write,
                bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.link, bus.is_signed,
                bus.alu_src_b, bus.pc_src};
    endfunction

    function automatic logic [2:0] sts_now();
        return {bus.timeout, bus.illegal_op, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        bus.opcode = op; bus.funct = fn; bus.zero = z; bus.mem_ready = rdy;
    endtask

    // Assert reset mid-cycle, check the cleared state, release; returns in the first live FETCH cycle.
    task automatic reset_to_run(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_state"}, 32'(bus.state_o), 32'd0);
        chk({tag, "_rst_memreq"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_rst_status"}, 32'(sts_now()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        drive(O_R, F_ADD, 1'b0, 1'b0);
        #1;
        chk("reset_state", 32'(bus.state_o), 32'd0);
        chk("reset_memreq", 32'(bus.mem_req), 32'd0);
        chk("reset_status", 32'(sts_now()), 32'd0);

        // row 0: first cycle after reset release, fetch not yet requested
        vecs.push_back(mk(O_R,   F_ADD, 0, 1, 3'd0, 15'b000_000_000_01_01_00, 5'd0, 3'b000));
        // ADD: FETCH, DECODE, EXEC, WB
        vecs.push_back(mk(O_R,   F_ADD, 0, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_R,   F_ADD, 0, 1, 3'd1, 15'b000_000_000_01_11_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_R,   F_ADD, 0, 1, 3'd2, 15'b000_000_001_01_00_00, 5'b00010, 3'b000));
        vecs.push_back(mk(O_R,   F_ADD, 0, 1, 3'd5, 15'b000_001_100_01_00_00, 5'd0, 3'b000));
        // ANDI: zero-extended immediate, and
        vecs.push_back(mk(O_AND, 6'd0,  0, 1, 3'd0, 15'b100_110_000_00_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_AND, 6'd0,  0, 1, 3'd1, 15'b000_000_000_00_11_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_AND, 6'd0,  0, 1, 3'd2, 15'b000_000_001_00_10_00, 5'b00100, 3'b000));
        vecs.push_back(mk(O_AND, 6'd0,  0, 1, 3'd5, 15'b000_001_000_00_00_00, 5'd0, 3'b000));
        // BEQ zero=1: taken
        vecs.push_back(mk(O_BEQ, 6'd0,  1, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_BEQ, 6'd0,  1, 1, 3'd1, 15'b000_000_000_01_11_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_BEQ, 6'd0,  1, 1, 3'd3, 15'b000_010_001_01_00_01, 5'b00001, 3'b000));
        // BNE zero=1: not taken
        vecs.push_back(mk(O_BNE, 6'd0,  1, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_BNE, 6'd0,  1, 1, 3'd1, 15'b000_000_000_01_11_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_BNE, 6'd0,  1, 1, 3'd3, 15'b000_000_001_01_00_01, 5'b00001, 3'b000));
        // J, JAL, JR resolve in DECODE
        vecs.push_back(mk(O_J,   6'd0,  0, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_J,   6'd0,  0, 1, 3'd1, 15'b000_010_000_01_11_10, 5'd0, 3'b000));
        vecs.push_back(mk(O_JAL, 6'd0,  0, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_JAL, 6'd0,  0, 1, 3'd1, 15'b000_011_000_11_11_10, 5'd0, 3'b000));
        vecs.push_back(mk(O_R,   F_JR,  0, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_R,   F_JR,  0, 1, 3'd1, 15'b000_010_000_01_11_11, 5'd0, 3'b000));
        // SW, zero-wait
        vecs.push_back(mk(O_SW,  6'd0,  0, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_SW,  6'd0,  0, 1, 3'd1, 15'b000_000_000_01_11_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_SW,  6'd0,  0, 1, 3'd2, 15'b000_000_001_01_10_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_SW,  6'd0,  0, 1, 3'd4, 15'b111_000_000_01_00_00, 5'd0, 3'b000));
        // LW with 3 data wait cycles: MEM held 4 cycles, 8 cycles total
        vecs.push_back(mk(O_LW,  6'd0,  0, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_LW,  6'd0,  0, 1, 3'd1, 15'b000_000_000_01_11_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_LW,  6'd0,  0, 0, 3'd2, 15'b000_000_001_01_10_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_LW,  6'd0,  0, 0, 3'd4, 15'b101_000_000_01_00_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_LW,  6'd0,  0, 0, 3'd4, 15'b101_000_000_01_00_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_LW,  6'd0,  0, 0, 3'd4, 15'b101_000_000_01_00_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_LW,  6'd0,  0, 1, 3'd4, 15'b101_000_000_01_00_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_LW,  6'd0,  0, 1, 3'd5, 15'b000_001_010_01_00_00, 5'd0, 3'b000));
        // XORI
        vecs.push_back(mk(O_XOR, 6'd0,  0, 1, 3'd0, 15'b100_110_000_00_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_XOR, 6'd0,  0, 1, 3'd1, 15'b000_000_000_00_11_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_XOR, 6'd0,  0, 1, 3'd2, 15'b000_000_001_00_10_00, 5'b00110, 3'b000));
        vecs.push_back(mk(O_XOR, 6'd0,  0, 1, 3'd5, 15'b000_001_000_00_00_00, 5'd0, 3'b000));
        // unlisted opcode
        vecs.push_back(mk(O_BAD, 6'd0,  0, 1, 3'd0, 15'b100_110_000_01_01_00, 5'd0, 3'b000));
        vecs.push_back(mk(O_BAD, 6'd0,  0, 0, 3'd1, 15'b000_000_000_01_11_00, 5'd0, 3'b000));
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        vecs.push_back(mk(O_BAD, 6'd0,  0, 0, 3'd6, 15'b000_000_000_01_00_00, 5'd0, 3'b011));
`else
        vecs.push_back(mk(O_BAD, 6'd0,  0, 0, 3'd0, 15'b100_000_000_01_01_00, 5'd0, 3'b000));
`endif

        @(negedge clk);
        rst = 1'b0;
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
            #1;
            chk($sformatf("row%0d_state", i), 32'(bus.state_o), 32'(vecs[i].st));
            chk($sformatf("row%0d_ctl", i), 32'(ctl_now()), 32'(vecs[i].ctl));
            chk($sformatf("row%0d_aluop", i), 32'(bus.alu_op), 32'(vecs[i].aop));
            chk($sformatf("row%0d_status", i), 32'(sts_now()), 32'(vecs[i].sts));
            @(negedge clk);
        end

        // Fetch starved: 15 stalled cycles tolerated, the 16th traps.
        reset_to_run("to");
        drive(O_R, F_ADD, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) @(negedge clk);
        #1;
        chk("to_pre_state", 32'(bus.state_o), 32'd0);
        chk("to_pre_memreq", 32'(bus.mem_req), 32'd1);
        chk("to_pre_timeout", 32'(bus.timeout), 32'd0);
        @(negedge clk);
        #1;
        chk("to_state", 32'(bus.state_o), 32'd6);
        chk("to_status", 32'(sts_now()), 32'b101);
        chk("to_ctl", 32'(ctl_now()), 32'(15'b000_000_000_01_00_00));
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) @(negedge clk);
        #1;
        chk("to_stuck_state", 32'(bus.state_o), 32'd6);
        chk("to_stuck_halted", 32'(bus.halted), 32'd1);

        // Ready arriving on the last tolerated cycle completes normally.
        reset_to_run("late");
        drive(O_R, F_ADD, 1'b0, 1'b0);
        for (int k = 0; k < 15; k++) @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk("late_irwrite", 32'(bus.ir_write), 32'd1);
        @(negedge clk);
        #1;
        chk("late_state", 32'(bus.state_o), 32'd1);
        chk("late_status", 32'(sts_now()), 32'd0);

        // Reset in the middle of a SW memory access.
        reset_to_run("sw");
        drive(O_SW, 6'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        chk("sw_mem_state", 32'(bus.state_o), 32'd4);
        chk("sw_mem_req_we", 32'({bus.mem_req, bus.mem_we}), 32'b11);
        #2 rst = 1'b1;
        #1;
        chk("sw_rst_req_we", 32'({bus.mem_req, bus.mem_we}), 32'b00);
        chk("sw_rst_state", 32'(bus.state_o), 32'd0);
        chk("sw_rst_status", 32'(sts_now()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("sw_release_memreq", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        #1;
        chk("sw_first_fetch", 32'({bus.mem_req, bus.i_or_d}), 32'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
